ram_image_loader: RTL
=====================

// Module: ram_image_loader
// PURPOSE
//  Writer-side counterpart of the mem read path: parses a byte stream of RAM.DAT-style
//  records ("@a c // comment", hex, whitespace-separated) and issues one write per record
//  to a mem instance through its address/memIn/write ports. Used to load programs and data
//  (e.g. ARRAY, SUM-ORRED, START words) at run time instead of at instantiation.
// PARAMETERS
//  ADDR_DIGITS  8  max hex digits accepted in an address field (>= 1, <= 8)
//  DATA_DIGITS  8  max hex digits accepted in a data field (>= 1, <= 8)
//  CHECK_ALIGN  1  1: address[1:0] != 0 is an error; 0: any byte address accepted
// PORTS
//  clk       in   1   clock; all state changes on posedge
//  reset     in   1   asynchronous, active-high reset
//  ch        in   8   ASCII character from the image source
//  ch_valid  in   1   ch is valid this cycle
//  ch_ready  out  1   loader accepts ch this cycle (transfer = ch_valid & ch_ready)
//  eof       in   1   end of image; level, sampled only when ch_valid = 0
//  address   out  32  mem address (byte address)
//  memIn     out  32  mem write data
//  read      out  1   mem read enable; constant 0
//  write     out  1   mem write enable; one-cycle pulse per record
//  words     out  16  records written since reset; saturates at 16'hFFFF
//  done      out  1   sticky: image loaded without error
//  error     out  1   sticky: malformed image; loading stopped
// BEHAVIOUR
//  - Reset (async): state SEEK; address, memIn, words = 0; read, write, done, error = 0;
//    ch_ready = 1 (registered, deasserts in WRITE/DONE/ERR).
//  - Char classes: HEX = 0-9 a-f A-F; WS = space, TAB, CR, LF; '@'; '/'; other = illegal.
//  - Hex accumulate: field = {field[27:0], nibble}; digit count tracked per field; digit
//    beyond ADDR_DIGITS/DATA_DIGITS -> ERR. Fields zero-extended to 32 bits.
//  - States / transitions (on accepted char unless noted):
//    SEEK   : WS stay; '@' -> ADDR (clear addr, count); '/' -> SLASH1; other -> ERR
//    ADDR   : HEX accumulate; WS with >=1 digit -> SEP (alignment check here); else ERR
//    SEP    : WS stay; HEX -> DATA (clear data, load nibble); other -> ERR
//    DATA   : HEX accumulate; WS -> WRITE(ret SEEK); '/' -> WRITE(ret SLASH1); other -> ERR
//    WRITE  : no char accepted; write = 1, address/memIn = parsed fields for exactly 1
//             cycle; words += 1 (saturating); next = return state
//    SLASH1 : '/' -> COMMENT; other -> ERR
//    COMMENT: any char stay; LF -> SEEK
//    DONE, ERR: absorbing until reset; ch_ready = 0, write = 0
//  - eof (ch_valid = 0): SEEK/COMMENT -> DONE; DATA with >=1 digit -> WRITE then DONE;
//    ADDR/SEP/SLASH1 -> ERR. ch_valid & eof same cycle: char consumed, eof ignored.
//  - address/memIn hold last written values after WRITE (mem sees write = 0).
//  - Latency: last data char (terminator) accepted in cycle N -> write high in cycle N+1.
//  - Duplicate addresses allowed; later record overwrites earlier in mem.
//  - reset mid-record: record discarded, no write issued; restart from SEEK.
// TESTING
//  1 "@0 1\n@4 3\n" then eof -> write pulses addr 0/data 1, addr 4/data 3; words = 2;
//    done = 1; readback via mem read gives 00000001, 00000003.
//  2 "@28 00000533 // add t5\n" then eof -> one write addr 0x28, data 0x533; comment
//    skipped; words = 1; done = 1.
//  3 "@6 5\n" with CHECK_ALIGN = 1 -> error = 1, write never pulses, ch_ready = 0.
//  4 "@10 123456789\n" (9 data digits) -> error = 1, no write; words = 0.
//  5 "@1c 7" then eof (no trailing WS) -> write addr 0x1c data 7, then done = 1;
//    "@1c" then eof -> error = 1.
//  6 reset asserted mid-DATA ("@20 ab" then reset) -> all outputs to reset values
//    immediately; then "@20 cd\n" + eof -> single write of 0xcd to 0x20, words = 1.

Source files
------------

// File: rtl/ram_image_loader.sv
// rtl/ram_image_loader.sv - RAM.DAT-style text image parser issuing one mem write per "@addr data" record
// Accepts one ASCII character per transfer; DONE and ERR hold until reset.
module ram_image_loader #(
  parameter int ADDR_DIGITS = 8,
  parameter int DATA_DIGITS = 8,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ch,
  input  logic        ch_valid,
  output logic        ch_ready,
  input  logic        eof,
  output logic [31:0] address,
  output logic [31:0] memIn,
  output logic        read,
  output logic        write,
  output logic [15:0] words,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    SEEK, ADDR, SEP, DATA, WRITE, SLASH1, COMMENT, DONE, ERR
  } state_t;

  state_t      state, state_n;
  state_t      ret, ret_n;
  logic [31:0] addr_f, addr_f_n;
  logic [31:0] data_f, data_f_n;
  logic [3:0]  addr_cnt, addr_cnt_n;
  logic [3:0]  data_cnt, data_cnt_n;

  logic        take, idle_eof;
  logic        is_hex, is_ws, is_at, is_slash, is_lf;
  logic [3:0]  nib;

  assign read = 1'b0;

  // Character classification
  always_comb begin
    is_hex   = 1'b0;
    nib      = 4'd0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      nib    = 4'(ch - 8'h30);
    end else if (ch >= 8'h61 && ch <= 8'h66) begin
      is_hex = 1'b1;
      nib    = 4'(ch - 8'h57);
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      is_hex = 1'b1;
      nib    = 4'(ch - 8'h37);
    end
    is_lf    = (ch == 8'h0a);
    is_ws    = (ch == 8'h20) || (ch == 8'h09) || (ch == 8'h0d) || is_lf;
    is_at    = (ch == 8'h40);
    is_slash = (ch == 8'h2f);
  end

  assign take     = ch_valid && ch_ready;
  assign idle_eof = !ch_valid && eof;

  always_comb begin
    state_n    = state;
    ret_n      = ret;
    addr_f_n   = addr_f;
    data_f_n   = data_f;
    addr_cnt_n = addr_cnt;
    data_cnt_n = data_cnt;
    case (state)
      SEEK: begin
        if (take) begin
          if (is_ws) state_n = SEEK;
          else if (is_at) begin
            state_n    = ADDR;
            addr_f_n   = 32'd0;
            addr_cnt_n = 4'd0;
          end else if (is_slash) state_n = SLASH1;
          else state_n = ERR;
        end else if (idle_eof) state_n = DONE;
      end
      ADDR: begin
        if (take) begin
          if (is_hex) begin
            if (addr_cnt == 4'(ADDR_DIGITS)) state_n = ERR;
            else begin
              addr_f_n   = {addr_f[27:0], nib};
              addr_cnt_n = addr_cnt + 4'd1;
            end
          end else if (is_ws && addr_cnt != 4'd0) begin
            if (CHECK_ALIGN && addr_f[1:0] != 2'b00) state_n = ERR;
            else state_n = SEP;
          end else state_n = ERR;
        end else if (idle_eof) state_n = ERR;
      end
      SEP: begin
        if (take) begin
          if (is_ws) state_n = SEP;
          else if (is_hex) begin
            state_n    = DATA;
            data_f_n   = {28'd0, nib};
            data_cnt_n = 4'd1;
          end else state_n = ERR;
        end else if (idle_eof) state_n = ERR;
      end
      DATA: begin
        if (take) begin
          if (is_hex) begin
            if (data_cnt == 4'(DATA_DIGITS)) state_n = ERR;
            else begin
              data_f_n   = {data_f[27:0], nib};
              data_cnt_n = data_cnt + 4'd1;
            end
          end else if (is_ws) begin
            state_n = WRITE;
            ret_n   = SEEK;
          end else if (is_slash) begin
            state_n = WRITE;
            ret_n   = SLASH1;
          end else state_n = ERR;
        end else if (idle_eof && data_cnt != 4'd0) begin
          state_n = WRITE;
          ret_n   = DONE;
        end else if (idle_eof) state_n = ERR;
      end
      WRITE: state_n = ret;
      SLASH1: begin
        if (take) state_n = is_slash ? COMMENT : ERR;
        else if (idle_eof) state_n = ERR;
      end
      COMMENT: begin
        if (take) begin
          if (is_lf) state_n = SEEK;
        end else if (idle_eof) state_n = DONE;
      end
      DONE:    state_n = DONE;
      ERR:     state_n = ERR;
      default: state_n = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SEEK;
      ret      <= SEEK;
      addr_f   <= 32'd0;
      data_f   <= 32'd0;
      addr_cnt <= 4'd0;
      data_cnt <= 4'd0;
      address  <= 32'd0;
      memIn    <= 32'd0;
      write    <= 1'b0;
      words    <= 16'd0;
      done     <= 1'b0;
      error    <= 1'b0;
      ch_ready <= 1'b1;
    end else begin
      state    <= state_n;
      ret      <= ret_n;
      addr_f   <= addr_f_n;
      data_f   <= data_f_n;
      addr_cnt <= addr_cnt_n;
      data_cnt <= data_cnt_n;
      write    <= (state_n == WRITE);
      done     <= (state_n == DONE);
      error    <= (state_n == ERR);
      ch_ready <= !(state_n == WRITE || state_n == DONE || state_n == ERR);
      // Outputs are loaded on entry to WRITE and then held for mem to see
      if (state_n == WRITE && state != WRITE) begin
        address <= addr_f_n;
        memIn   <= data_f_n;
        if (words != 16'hFFFF) words <= words + 16'd1;
      end
    end
  end

endmodule
